// File: rtl/hdc_pkg.sv
// Shared HDC definitions: default hypervector width, width helpers, classifier FSM states.
package hdc_pkg;

    localparam int DIMENSIONS_DEF = 10000;

    function automatic int dist_w(input int dims);
        return $clog2(dims + 1);
    endfunction

    function automatic int class_w(input int num_classes);
        return (num_classes > 1) ? $clog2(num_classes) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        ARGMIN  = 2'd2
    } cls_state_t;

endpackage

// File: rtl/hv_classifier_if.sv
// Window/prototype inputs and decision outputs of the associative-memory classifier.
interface hv_classifier_if
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS  = DIMENSIONS_DEF,
    parameter int NUM_CLASSES = 2
);
    localparam int DIST_W  = dist_w(DIMENSIONS);
    localparam int CLASS_W = class_w(NUM_CLASSES);

    logic [DIMENSIONS-1:0]                  window_hv;
    logic                                   window_valid;
    logic                                   ready;
    logic [NUM_CLASSES-1:0][DIMENSIONS-1:0] class_hv;
    logic [CLASS_W-1:0]                     class_out;
    logic [NUM_CLASSES-1:0][DIST_W-1:0]     dist_out;
    logic                                   out_valid;
    logic                                   overrun;

    modport master (
        output window_hv, window_valid, class_hv,
        input  ready, class_out, dist_out, out_valid, overrun
    );

    modport slave (
        input  window_hv, window_valid, class_hv,
        output ready, class_out, dist_out, out_valid, overrun
    );
endinterface

// File: rtl/hv_classifier_popcount.sv
// Combinational popcount of one CHUNK-bit slice; zero latency, no flow control.
module chunk_popcount #(
    parameter int CHUNK = 500
) (
    input  logic [CHUNK-1:0]             bits,
    output logic [$clog2(CHUNK+1)-1:0]   count
);
    localparam int CNT_W = $clog2(CHUNK + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end
endmodule

// File: rtl/hv_classifier.sv
// Nearest-prototype classifier: Hamming distance scanned CHUNK bits/cycle, result NUM_CHUNKS+1 edges after accept.
// ready is low while busy; windows offered then are dropped and flagged in sticky overrun.
module hv_classifier
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS  = DIMENSIONS_DEF,
    parameter int NUM_CLASSES = 2,
    parameter int CHUNK       = 500
) (
    input  logic          clk,
    input  logic          nrst,
    hv_classifier_if.slave bus
);
    localparam int NUM_CHUNKS = DIMENSIONS / CHUNK;
    localparam int DIST_W     = dist_w(DIMENSIONS);
    localparam int CLASS_W    = class_w(NUM_CLASSES);
    localparam int PC_W       = $clog2(CHUNK + 1);
    localparam int CIDX_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    generate
        if (DIMENSIONS % CHUNK != 0) begin : g_bad_chunk
            $error("hv_classifier: CHUNK must divide DIMENSIONS exactly");
        end
    endgenerate

    cls_state_t                          state;
    logic [CIDX_W-1:0]                   chunk_idx;
    logic [DIMENSIONS-1:0]               win;
    logic [NUM_CLASSES-1:0][DIST_W-1:0]  acc;
    logic [NUM_CLASSES-1:0][PC_W-1:0]    pc;
    logic [CHUNK-1:0]                    win_chunk;
    logic [CLASS_W-1:0]                  best_idx;
    logic [DIST_W-1:0]                   best_val;
    logic [CLASS_W-1:0]                  class_q;
    logic [NUM_CLASSES-1:0][DIST_W-1:0]  dist_q;
    logic                                out_valid_q;
    logic                                overrun_q;

    // Indexed part-select keeps the mux to one CHUNK-wide slice per cycle.
    assign win_chunk = win[chunk_idx*CHUNK +: CHUNK];

    generate
        for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pc
            chunk_popcount #(.CHUNK(CHUNK)) u_pc (
                .bits  (win_chunk ^ bus.class_hv[c][chunk_idx*CHUNK +: CHUNK]),
                .count (pc[c])
            );
        end
    endgenerate

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = acc[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (acc[c] < best_val) begin
                best_val = acc[c];
                best_idx = CLASS_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= IDLE;
            chunk_idx   <= '0;
            win         <= '0;
            acc         <= '0;
            class_q     <= '0;
            dist_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.window_valid && state != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.window_valid) begin
                        win       <= bus.window_hv;
                        chunk_idx <= '0;
                        acc       <= '0;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        acc[c] <= acc[c] + DIST_W'(pc[c]);
                    end
                    if (chunk_idx == CIDX_W'(NUM_CHUNKS - 1)) begin
                        state <= ARGMIN;
                    end else begin
                        chunk_idx <= chunk_idx + 1'b1;
                    end
                end
                ARGMIN: begin
                    class_q     <= best_idx;
                    dist_q      <= acc;
                    out_valid_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.class_out = class_q;
    assign bus.dist_out  = dist_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_hv_classifier.sv
// Directed bench for hv_classifier at defaults: prototypes all-0 and all-1, hand-computed distances.
module tb_hv_classifier;
    localparam int D = 10000;
    localparam int N = 2;

    logic clk;
    logic nrst;
    int   vectors;
    int   miscompares;

    hv_classifier_if #(.DIMENSIONS(D), .NUM_CLASSES(N)) bus ();

    hv_classifier #(.DIMENSIONS(D), .NUM_CLASSES(N), .CHUNK(500)) u_dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [D-1:0] ones(input int n);
        logic [D-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Offers one window so that the next posedge is the accept edge; returns #1 after it.
    task automatic present(input logic [D-1:0] hv);
        @(negedge clk);
        bus.window_hv    = hv;
        bus.window_valid = 1'b1;
        @(posedge clk);
        #1 bus.window_valid = 1'b0;
    endtask

    // k=1 is the cycle after the accept edge; out_valid is expected at k=22.
    task automatic watch(input int n, output int lat, output int pulses);
        lat    = -1;
        pulses = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.window_valid = 1'b1;
        bus.window_hv    = '1;
        repeat (2) @(posedge clk);
        #1 bus.window_valid = 1'b0;
        nrst = 1'b1;
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
        vectors++; if (bus.class_out !== 1'b0) begin miscompares++; $display("FAIL reset_class got %0d exp 0", bus.class_out); end
        vectors++; if (bus.dist_out[0] !== 14'd0 || bus.dist_out[1] !== 14'd0) begin
            miscompares++; $display("FAIL reset_dist got {%0d,%0d} exp {0,0}", bus.dist_out[0], bus.dist_out[1]);
        end
    endtask

    task automatic test_all_zero();
        int lat, pulses;
        present('0);
        watch(30, lat, pulses);
        vectors++; if (lat !== 22) begin miscompares++; $display("FAIL zero_latency got %0d exp 22", lat); end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL zero_pulses got %0d exp 1", pulses); end
        vectors++; if (bus.dist_out[0] !== 14'd0 || bus.dist_out[1] !== 14'd10000) begin
            miscompares++; $display("FAIL zero_dist got {%0d,%0d} exp {0,10000}", bus.dist_out[0], bus.dist_out[1]);
        end
        vectors++; if (bus.class_out !== 1'b0) begin miscompares++; $display("FAIL zero_class got %0d exp 0", bus.class_out); end
    endtask

    task automatic test_patterns();
        int lat, pulses;
        present(ones(3000));
        watch(30, lat, pulses);
        vectors++; if (bus.dist_out[0] !== 14'd3000 || bus.dist_out[1] !== 14'd7000) begin
            miscompares++; $display("FAIL p3000_dist got {%0d,%0d} exp {3000,7000}", bus.dist_out[0], bus.dist_out[1]);
        end
        vectors++; if (bus.class_out !== 1'b0) begin miscompares++; $display("FAIL p3000_class got %0d exp 0", bus.class_out); end
        present(ones(7000));
        watch(30, lat, pulses);
        vectors++; if (bus.dist_out[0] !== 14'd7000 || bus.dist_out[1] !== 14'd3000) begin
            miscompares++; $display("FAIL p7000_dist got {%0d,%0d} exp {7000,3000}", bus.dist_out[0], bus.dist_out[1]);
        end
        vectors++; if (bus.class_out !== 1'b1) begin miscompares++; $display("FAIL p7000_class got %0d exp 1", bus.class_out); end
    endtask

    task automatic test_tie();
        int lat, pulses;
        present(ones(5000));
        watch(30, lat, pulses);
        vectors++; if (bus.dist_out[0] !== 14'd5000 || bus.dist_out[1] !== 14'd5000) begin
            miscompares++; $display("FAIL tie_dist got {%0d,%0d} exp {5000,5000}", bus.dist_out[0], bus.dist_out[1]);
        end
        vectors++; if (bus.class_out !== 1'b0) begin miscompares++; $display("FAIL tie_class got %0d exp 0", bus.class_out); end
    endtask

    task automatic test_back_to_back();
        int lat, pulses, k1;
        present(ones(3000));
        k1 = -1;
        for (int k = 1; k <= 40 && k1 < 0; k++) begin
            @(negedge clk);
            if (bus.out_valid) k1 = k;
        end
        vectors++; if (k1 !== 22) begin miscompares++; $display("FAIL b2b_first_latency got %0d exp 22", k1); end
        vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_in_valid_cycle got %b exp 1", bus.ready); end
        // Still inside the out_valid cycle: the next edge is the second accept.
        bus.window_hv    = ones(7000);
        bus.window_valid = 1'b1;
        @(posedge clk);
        #1 bus.window_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_after_accept got %b exp 0", bus.ready); end
        watch(30, lat, pulses);
        // watch starts one cycle later than usual, so 22 cycles from accept reads as 21.
        vectors++; if (lat !== 21) begin miscompares++; $display("FAIL b2b_second_latency got %0d exp 21", lat); end
        vectors++; if (bus.dist_out[0] !== 14'd7000 || bus.dist_out[1] !== 14'd3000) begin
            miscompares++; $display("FAIL b2b_dist got {%0d,%0d} exp {7000,3000}", bus.dist_out[0], bus.dist_out[1]);
        end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun got %b exp 0", bus.overrun); end
    endtask

    task automatic test_overrun();
        int lat;
        present('0);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.out_valid && lat < 0) lat = k;
            if (k == 5) begin
                bus.window_hv    = '1;
                bus.window_valid = 1'b1;
            end else begin
                bus.window_valid = 1'b0;
            end
        end
        vectors++; if (lat !== 22) begin miscompares++; $display("FAIL ovr_latency got %0d exp 22", lat); end
        vectors++; if (bus.dist_out[0] !== 14'd0 || bus.dist_out[1] !== 14'd10000) begin
            miscompares++; $display("FAIL ovr_dist got {%0d,%0d} exp {0,10000}", bus.dist_out[0], bus.dist_out[1]);
        end
        vectors++; if (bus.class_out !== 1'b0) begin miscompares++; $display("FAIL ovr_class got %0d exp 0", bus.class_out); end
        vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set got %b exp 1", bus.overrun); end
        repeat (10) @(negedge clk);
        vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %b exp 1", bus.overrun); end
        vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL ovr_ready got %b exp 1", bus.ready); end
    endtask

    task automatic test_abort();
        int lat, pulses;
        present(ones(3000));
        // Chunk 10 is processed at accept+11; hold nrst low for exactly that edge.
        repeat (10) @(posedge clk);
        #1 nrst = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got %b exp 1", bus.ready); end
        vectors++; if (bus.dist_out[0] !== 14'd0 || bus.dist_out[1] !== 14'd0) begin
            miscompares++; $display("FAIL abort_dist got {%0d,%0d} exp {0,0}", bus.dist_out[0], bus.dist_out[1]);
        end
        vectors++; if (bus.class_out !== 1'b0) begin miscompares++; $display("FAIL abort_class got %0d exp 0", bus.class_out); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL abort_overrun got %b exp 0", bus.overrun); end
        watch(40, lat, pulses);
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL abort_no_valid got %0d exp 0", pulses); end
        present(ones(7000));
        watch(30, lat, pulses);
        vectors++; if (lat !== 22) begin miscompares++; $display("FAIL abort_next_latency got %0d exp 22", lat); end
        vectors++; if (bus.dist_out[0] !== 14'd7000 || bus.dist_out[1] !== 14'd3000) begin
            miscompares++; $display("FAIL abort_next_dist got {%0d,%0d} exp {7000,3000}", bus.dist_out[0], bus.dist_out[1]);
        end
        vectors++; if (bus.class_out !== 1'b1) begin miscompares++; $display("FAIL abort_next_class got %0d exp 1", bus.class_out); end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        nrst             = 1'b0;
        bus.window_valid = 1'b0;
        bus.window_hv    = '0;
        bus.class_hv[0]  = '0;
        bus.class_hv[1]  = '1;
        test_reset();
        test_all_zero();
        test_patterns();
        test_tie();
        test_back_to_back();
        test_overrun();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
